// File: rtl/rvfi_liveness_sequencer_if.sv
// RVFI retire-port bundle seen by the liveness sequencer.
// The core side (or bench) drives it through the master modport.
// The sequencer observes it through the slave modport.
interface rvfi_liveness_sequencer_if #(
    parameter int NRET = 1
) ();
    logic [NRET-1:0]    rvfi_valid;
    logic [NRET-1:0]    rvfi_halt;
    logic [64*NRET-1:0] rvfi_order;

    modport master (
        output rvfi_valid,
        output rvfi_halt,
        output rvfi_order
    );

    modport slave (
        input rvfi_valid,
        input rvfi_halt,
        input rvfi_order
    );
endinterface

// File: rtl/rvfi_liveness_sequencer.sv
// Trigger/check strobe sequencer for the RVFI liveness checker.
// After a settle time it fires o_trig on the first non-halting retirement of
// the checked channel, fires o_check CHECK_DEPTH cycles later, then sits in DONE.
// It also flags whether the successor instruction (order+1) retired.
// The optional halt-abort feature is enabled by defining RVFI_LIVENESS_SEQ_HALT_ABORT_EN.
// When it is enabled, an extra o_aborted port is present.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | settle counter running, no trigger permitted
// ARMED  | waiting for a non-halting retirement on CHANNEL_IDX
// WAIT   | window counter running down after the trigger
// CHECK  | one-cycle check strobe
// DONE   | sequence finished, terminal until reset
module rvfi_liveness_sequencer #(
    parameter int NRET           = 1,
    parameter int CHANNEL_IDX    = 0,
    parameter int TRIG_MIN_CYCLE = 10,
    parameter int CHECK_DEPTH    = 20,
    parameter int CNT_W          = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    rvfi_liveness_sequencer_if.slave       i_rvfi,
    output logic                           o_trig,
    output logic                           o_check,
    output logic                           o_armed,
    output logic [63:0]                    o_trig_order,
    output logic                           o_next_seen,
    output logic                           o_done
`ifdef RVFI_LIVENESS_SEQ_HALT_ABORT_EN
    ,
    output logic                           o_aborted
`endif
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARMED = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] TRIG_MIN  = CNT_W'(TRIG_MIN_CYCLE);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'((TRIG_MIN_CYCLE == 0) ? 0 : TRIG_MIN_CYCLE - 1);
    localparam logic [CNT_W-1:0] WIN_LOAD  = CNT_W'((CHECK_DEPTH < 1) ? 0 : CHECK_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_win_cnt;
    logic [63:0]      r_trig_order;
    logic             r_next_seen;

    logic             w_trig;
    logic [63:0]      w_ch_order;
    logic [63:0]      w_succ_ref;
    logic             w_succ_hit;
    logic             w_succ_en;
    logic             w_halt_any;

    assign w_ch_order = i_rvfi.rvfi_order[64*CHANNEL_IDX +: 64];
    assign w_trig     = (r_state == S_ARMED) && i_rvfi.rvfi_valid[CHANNEL_IDX]
                        && !i_rvfi.rvfi_halt[CHANNEL_IDX] && !reset;
    assign w_halt_any = |(i_rvfi.rvfi_valid & i_rvfi.rvfi_halt);

    // In the trigger cycle the captured order is not yet registered, so the
    // successor is referenced from the live channel order instead.
    assign w_succ_ref = (r_state == S_ARMED) ? (w_ch_order + 64'd1) : (r_trig_order + 64'd1);
    assign w_succ_en  = w_trig || (r_state == S_WAIT) || (r_state == S_CHECK);

    // Successor match across all retire channels.
    always_comb begin
        w_succ_hit = 1'b0;
        for (int k = 0; k < NRET; k++) begin
            if (i_rvfi.rvfi_valid[k] && (i_rvfi.rvfi_order[64*k +: 64] == w_succ_ref))
                w_succ_hit = 1'b1;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (TRIG_MIN_CYCLE == 0 || r_cycle_cnt == TRIG_LAST) w_state_nxt = S_ARMED;
            S_ARMED: if (w_trig) w_state_nxt = (CHECK_DEPTH <= 1) ? S_CHECK : S_WAIT;
            S_WAIT: begin
`ifdef RVFI_LIVENESS_SEQ_HALT_ABORT_EN
                if (w_halt_any)
                    w_state_nxt = S_DONE;
                else
`endif
                if (r_win_cnt <= CNT_ONE)
                    w_state_nxt = S_CHECK;
            end
            S_CHECK: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, counters, trigger capture and sticky successor flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cycle_cnt  <= '0;
            r_win_cnt    <= '0;
            r_trig_order <= '0;
            r_next_seen  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_cycle_cnt != TRIG_MIN)
                r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
            if (w_trig) begin
                r_trig_order <= w_ch_order;
                r_win_cnt    <= WIN_LOAD;
            end else if (r_state == S_WAIT && r_win_cnt != '0) begin
                r_win_cnt <= r_win_cnt - CNT_ONE;
            end
            if (w_succ_en && w_succ_hit)
                r_next_seen <= 1'b1;
        end
    end

`ifdef RVFI_LIVENESS_SEQ_HALT_ABORT_EN
    logic r_aborted;

    // Sticky record that a halt cut the window short.
    always_ff @(posedge clock) begin
        if (reset)
            r_aborted <= 1'b0;
        else if (r_state == S_WAIT && w_halt_any)
            r_aborted <= 1'b1;
    end

    assign o_aborted = r_aborted;
`else
    logic w_halt_unused;
    assign w_halt_unused = w_halt_any;
`endif

    assign o_trig       = w_trig;
    assign o_check      = (r_state == S_CHECK);
    assign o_armed      = (r_state == S_ARMED);
    assign o_done       = (r_state == S_DONE);
    assign o_trig_order = r_trig_order;
    assign o_next_seen  = r_next_seen;

endmodule

// File: doc/rvfi_liveness_sequencer.md
Name: rvfi_liveness_sequencer

Overview:
Generates the `trig` and `check` strobes for the RVFI liveness checker.
- Sits between the core's RVFI retire ports and the liveness check; sees the same RVFI signals.
- After a programmable settle time, picks the first non-halting retirement on the checked channel as the trigger instruction and fires `trig` in that same cycle.
- After a fixed window it fires `check` once, then goes sticky-done.
- Also reports whether the successor retirement (order+1) was observed, for bench cover/debug.

Parameters:
- NRET, 1, number of RVFI retire channels.
- CHANNEL_IDX, 0, channel whose retirement may trigger (0..NRET-1).
- TRIG_MIN_CYCLE, 10, cycles after reset release before a trigger is permitted.
- CHECK_DEPTH, 20, cycles from the trigger cycle to the check cycle (≥1).
- CNT_W, 16, width of internal counters; must hold max(TRIG_MIN_CYCLE, CHECK_DEPTH).

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- rvfi_valid  in  NRET  retire valid per channel.
- rvfi_halt  in  NRET  retire halt per channel.
- rvfi_order  in  64*NRET  retire order; channel k occupies [64*k +: 64].
- trig  out  1  trigger strobe, same-cycle with the qualifying retirement.
- check  out  1  one-cycle check strobe.
- armed  out  1  high while waiting for the trigger retirement.
- trig_order  out  64  captured order of the trigger instruction.
- next_seen  out  1  sticky: order trig_order+1 retired on any channel.
- done  out  1  sticky: sequence finished.

Behaviour:
Reset and encoding
- Interface: reset is `reset`, synchronous, active-high; clock is `clock`.
- During reset all registered state clears: state=IDLE, counters=0, trig_order=0, next_seen=0, done=0.
- `trig` is forced 0 while reset is high.

States
- IDLE: cycle counter increments each non-reset cycle, saturating at TRIG_MIN_CYCLE. When counter==TRIG_MIN_CYCLE-1, the next state is ARMED. TRIG_MIN_CYCLE=0 goes to ARMED on the first cycle after reset.
- ARMED: `armed`=1.
  - Combinational: trig = ARMED && rvfi_valid[CHANNEL_IDX] && !rvfi_halt[CHANNEL_IDX] && !reset.
  - On trig: capture trig_order = rvfi_order[CHANNEL_IDX], load the window counter with CHECK_DEPTH-1, go to WAIT.
  - Halting or invalid retirements do not trigger; the block stays in ARMED indefinitely.
- WAIT: window counter decrements each cycle; at 0 the next state is CHECK. CHECK_DEPTH=1 goes directly to CHECK the cycle after trig.
- CHECK: `check`=1 for exactly one cycle (registered state decode); the next state is DONE.
- DONE: `done`=1; terminal until reset. trig and check stay 0.

Successor detection (next_seen)
- Set when any channel k has rvfi_valid[k] && rvfi_order[k] == trig_order+1, evaluated in WAIT and in CHECK.
- Also set in the trig cycle itself, comparing against rvfi_order[CHANNEL_IDX]+1 (covers same-cycle multi-retire when NRET>1).
- Addition is 64-bit modulo; 0xFFFF_FFFF_FFFF_FFFF+1 = 0.
- Never cleared except by reset.

Boundary conditions
- Reset asserted mid-WAIT or in CHECK aborts the sequence; no check is issued; next cycle is IDLE with count restarting.
- Only one trigger per reset epoch.

Optional Feature:
Macro RVFI_LIVENESS_SEQ_HALT_ABORT_EN.
- Defined: any rvfi_valid[k]&&rvfi_halt[k] in WAIT moves directly to DONE with no check pulse, and sets an extra output `aborted`=1 (sticky, reset 0).
- Undefined: halts in WAIT are ignored, `aborted` is absent, and the window always completes.

Test Plan:
1. TRIG_MIN_CYCLE=10, valid every cycle from cycle 0 after reset, orders 0,1,2…: trig is 0 on cycles 0–9 and 1 on cycle 10 with trig_order=10; check=1 exactly on cycle 30 (CHECK_DEPTH=20); next_seen=1 from cycle 12; done=1 from cycle 31.
2. In ARMED, cycle 10 has valid=1,halt=1, cycle 11 has valid=0, cycle 12 has valid=1,halt=0 order=7: trig only on cycle 12; trig_order=7.
3. NRET=2, CHANNEL_IDX=0, trig cycle with ch0 order 5 and ch1 order 6 both valid: next_seen=1 on the following cycle.
4. Reset pulsed 5 cycles after trig: check never asserts in that epoch; the sequence restarts; the second trig requires a further 10 cycles.
5. trig_order=0xFFFF_FFFF_FFFF_FFFF, later retirement with order 0: next_seen=1.
6. With RVFI_LIVENESS_SEQ_HALT_ABORT_EN defined, halt retires 3 cycles after trig: check stays 0; done=1 and aborted=1 from the next cycle.
